controle_multiciclo: RTL and testbench

- Multi-cycle main control FSM for the RV32I core.
- Sequences one shared ALU, register file and a single unified instruction/data memory through fetch, decode, execute, memory and write-back steps.
- Decodes the same five opcode classes as the single-cycle decoder: R, I-immediate, I-load, S-store, B-branch.
- Waits on a memory ready handshake, and traps on illegal opcodes.

---
 rtl/controle_multiciclo.sv | 163 ++++++++++++++++
 tb/tb_controle_multiciclo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multi-cycle main control FSM for the RV32I core (fetch/decode/execute/memory/write-back).
// Optional retired-instruction counter enabled by defining CONTADOR_INSTRUCOES_EN.
module controle_multiciclo #(
  parameter int LARGURA_CONTADOR = 32,
  parameter int ESTADO_W         = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Habilita,
  input  logic [6:0]                  CodigoDaOperacao,
  input  logic                        Zero,
  input  logic                        MemPronta,
  output logic                        EscrevePC,
  output logic                        EscreveIR,
  output logic                        IouD,
  output logic                        LeMemoria,
  output logic                        EscreveMemoria,
  output logic                        EscreveRegistrador,
  output logic                        FonteULA,
  output logic                        MemParaReg,
  output logic [1:0]                  OperacaoULA,
  output logic                        Desvio,
  output logic                        Ilegal,
`ifdef CONTADOR_INSTRUCOES_EN
  output logic [LARGURA_CONTADOR-1:0] InstrRetiradas,
`endif
  output logic [ESTADO_W-1:0]         Estado
);

  localparam logic [3:0] INICIO      = 4'd0;
  localparam logic [3:0] BUSCA       = 4'd1;
  localparam logic [3:0] DECODIFICA  = 4'd2;
  localparam logic [3:0] EXECUTA     = 4'd3;
  localparam logic [3:0] ESCRITA_ULA = 4'd4;
  localparam logic [3:0] CALC_END    = 4'd5;
  localparam logic [3:0] LE_MEM      = 4'd6;
  localparam logic [3:0] ESCRITA_MEM = 4'd7;
  localparam logic [3:0] ESC_MEM     = 4'd8;
  localparam logic [3:0] DESVIO      = 4'd9;
  localparam logic [3:0] ILEGAL      = 4'd10;

  localparam logic [2:0] CL_NENHUMA = 3'd0;
  localparam logic [2:0] CL_R       = 3'd1;
  localparam logic [2:0] CL_IMM     = 3'd2;
  localparam logic [2:0] CL_LOAD    = 3'd3;
  localparam logic [2:0] CL_STORE   = 3'd4;
  localparam logic [2:0] CL_BRANCH  = 3'd5;

  logic [3:0] estado;
  logic [3:0] proximo;
  logic [2:0] classe;
  logic [2:0] classe_dec;

  always_comb begin
    classe_dec = CL_NENHUMA;
    case (CodigoDaOperacao)
      7'b0110011: classe_dec = CL_R;
      7'b0010011: classe_dec = CL_IMM;
      7'b0000011: classe_dec = CL_LOAD;
      7'b0100011: classe_dec = CL_STORE;
      7'b1100011: classe_dec = CL_BRANCH;
      default:    classe_dec = CL_NENHUMA;
    endcase
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIO:      if (Habilita) proximo = BUSCA;
      BUSCA:       if (MemPronta) proximo = DECODIFICA;
      DECODIFICA: begin
        case (classe_dec)
          CL_R, CL_IMM:       proximo = EXECUTA;
          CL_LOAD, CL_STORE:  proximo = CALC_END;
          CL_BRANCH:          proximo = DESVIO;
          default:            proximo = ILEGAL;
        endcase
      end
      EXECUTA:     proximo = ESCRITA_ULA;
      ESCRITA_ULA: proximo = INICIO;
      // Load vs store is resolved from the latched class, not the live opcode.
      CALC_END:    proximo = (classe == CL_LOAD) ? LE_MEM : ESC_MEM;
      LE_MEM:      if (MemPronta) proximo = ESCRITA_MEM;
      ESCRITA_MEM: proximo = INICIO;
      ESC_MEM:     if (MemPronta) proximo = INICIO;
      DESVIO:      proximo = INICIO;
      ILEGAL:      proximo = ILEGAL;
      default:     proximo = INICIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= INICIO;
      classe <= CL_NENHUMA;
    end else begin
      estado <= proximo;
      if (estado == DECODIFICA) classe <= classe_dec;
    end
  end

  always_comb begin
    EscrevePC          = 1'b0;
    EscreveIR          = 1'b0;
    IouD               = 1'b0;
    LeMemoria          = 1'b0;
    EscreveMemoria     = 1'b0;
    EscreveRegistrador = 1'b0;
    FonteULA           = 1'b0;
    MemParaReg         = 1'b0;
    OperacaoULA        = 2'b00;
    Desvio             = 1'b0;
    Ilegal             = 1'b0;
    case (estado)
      BUSCA: begin
        LeMemoria = 1'b1;
        EscreveIR = MemPronta;
        EscrevePC = MemPronta;
      end
      EXECUTA: begin
        OperacaoULA = 2'b10;
        FonteULA    = (classe == CL_IMM);
      end
      ESCRITA_ULA: EscreveRegistrador = 1'b1;
      CALC_END:    FonteULA = 1'b1;
      LE_MEM: begin
        LeMemoria = 1'b1;
        IouD      = 1'b1;
      end
      ESCRITA_MEM: begin
        EscreveRegistrador = 1'b1;
        MemParaReg         = 1'b1;
      end
      ESC_MEM: begin
        EscreveMemoria = 1'b1;
        IouD           = 1'b1;
        FonteULA       = 1'b1;
      end
      DESVIO: begin
        Desvio      = 1'b1;
        OperacaoULA = 2'b01;
        EscrevePC   = Zero;
      end
      ILEGAL:  Ilegal = 1'b1;
      default: ;
    endcase
  end

  assign Estado = ESTADO_W'(estado);

`ifdef CONTADOR_INSTRUCOES_EN
  logic retira;
  assign retira = (proximo == INICIO) &&
                  ((estado == ESCRITA_ULA) || (estado == ESCRITA_MEM) ||
                   (estado == ESC_MEM) || (estado == DESVIO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) InstrRetiradas <= '0;
    else if (retira) InstrRetiradas <= InstrRetiradas + 1'b1;
  end
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: stimulus queues per-cycle expectations, monitor checks them.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Habilita = 1'b0;
  logic [6:0]  CodigoDaOperacao = 7'd0;
  logic        Zero = 1'b0;
  logic        MemPronta = 1'b0;
  logic        EscrevePC, EscreveIR, IouD, LeMemoria, EscreveMemoria;
  logic        EscreveRegistrador, FonteULA, MemParaReg, Desvio, Ilegal;
  logic [1:0]  OperacaoULA;
  logic [3:0]  Estado;
`ifdef CONTADOR_INSTRUCOES_EN
  logic [3:0]  InstrRetiradas;
`endif

  controle_multiciclo #(.LARGURA_CONTADOR(4), .ESTADO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Habilita(Habilita),
    .CodigoDaOperacao(CodigoDaOperacao), .Zero(Zero), .MemPronta(MemPronta),
    .EscrevePC(EscrevePC), .EscreveIR(EscreveIR), .IouD(IouD),
    .LeMemoria(LeMemoria), .EscreveMemoria(EscreveMemoria),
    .EscreveRegistrador(EscreveRegistrador), .FonteULA(FonteULA),
    .MemParaReg(MemParaReg), .OperacaoULA(OperacaoULA), .Desvio(Desvio),
    .Ilegal(Ilegal),
`ifdef CONTADOR_INSTRUCOES_EN
    .InstrRetiradas(InstrRetiradas),
`endif
    .Estado(Estado)
  );

  always #5 clk = ~clk;

  // Control vector bit order:
  // {EscrevePC,EscreveIR,IouD,LeMemoria,EscreveMemoria,EscreveRegistrador,FonteULA,MemParaReg,OperacaoULA,Desvio,Ilegal}
  localparam logic [11:0] NADA = 12'h000;
  localparam logic [11:0] PC   = 12'h800;
  localparam logic [11:0] IR   = 12'h400;
  localparam logic [11:0] IOD  = 12'h200;
  localparam logic [11:0] LM   = 12'h100;
  localparam logic [11:0] EM   = 12'h080;
  localparam logic [11:0] ER   = 12'h040;
  localparam logic [11:0] FU   = 12'h020;
  localparam logic [11:0] MR   = 12'h010;
  localparam logic [11:0] OPF  = 12'h008;
  localparam logic [11:0] OPB  = 12'h004;
  localparam logic [11:0] DS   = 12'h002;
  localparam logic [11:0] IL   = 12'h001;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_XX = 7'b1111111;

  typedef struct {
    logic [3:0]  est;
    logic [11:0] ctl;
    string       nome;
  } esp_t;

  esp_t fila[$];
  int   total = 0;
  int   passou = 0;

  logic [11:0] ctl_obs;
  assign ctl_obs = {EscrevePC, EscreveIR, IouD, LeMemoria, EscreveMemoria,
                    EscreveRegistrador, FonteULA, MemParaReg, OperacaoULA,
                    Desvio, Ilegal};

  always @(negedge clk) begin : monitor
    esp_t e;
    if (fila.size() > 0) begin
      e = fila.pop_front();
      total++;
      if (Estado === e.est) passou++;
      else $display("FAIL %s estado: got %0d expected %0d", e.nome, Estado, e.est);
      total++;
      if (ctl_obs === e.ctl) passou++;
      else $display("FAIL %s controles: got %b expected %b", e.nome, ctl_obs, e.ctl);
    end
  end

  // Drive one cycle's inputs just after the edge and queue what the DUT must show this cycle.
  task automatic cyc(input logic r, input logic h, input logic [6:0] op,
                     input logic z, input logic mp, input logic [3:0] est,
                     input logic [11:0] ctl, input string nome);
    esp_t e;
    @(posedge clk);
    #1;
    rst_n = r; Habilita = h; CodigoDaOperacao = op; Zero = z; MemPronta = mp;
    e.est = est; e.ctl = ctl; e.nome = nome;
    fila.push_back(e);
  endtask

`ifdef CONTADOR_INSTRUCOES_EN
  task automatic check_cnt(input logic [3:0] esperado, input string nome);
    total++;
    if (InstrRetiradas === esperado) passou++;
    else $display("FAIL %s: got %0d expected %0d", nome, InstrRetiradas, esperado);
  endtask
`endif

  initial begin
    cyc(0, 0, 7'd0, 0, 0, 4'd0, NADA, "reset");
    cyc(1, 1, 7'd0, 0, 0, 4'd0, NADA, "inicio_hab");
    // R-type, no wait states; opcode garbled after decode must not matter
    cyc(1, 1, OP_R,  0, 1, 4'd1, PC|IR|LM, "r_busca");
    cyc(1, 1, OP_R,  0, 1, 4'd2, NADA,     "r_decod");
    cyc(1, 1, OP_XX, 0, 1, 4'd3, OPF,      "r_exec");
    cyc(1, 0, OP_XX, 0, 1, 4'd4, ER,       "r_escrita");
    cyc(1, 0, OP_XX, 0, 1, 4'd0, NADA,     "r_inicio_hold");
    cyc(1, 1, OP_XX, 0, 1, 4'd0, NADA,     "i_inicio");
    // I-immediate with one fetch wait; live opcode flips to R in EXECUTA
    cyc(1, 1, OP_I, 0, 0, 4'd1, LM,          "i_busca_wait");
    cyc(1, 1, OP_I, 0, 1, 4'd1, PC|IR|LM,    "i_busca");
    cyc(1, 1, OP_I, 0, 1, 4'd2, NADA,        "i_decod");
    cyc(1, 1, OP_R, 0, 1, 4'd3, OPF|FU,      "i_exec_fonte");
    cyc(1, 1, OP_R, 0, 1, 4'd4, ER,          "i_escrita");
    cyc(1, 1, OP_LD, 0, 1, 4'd0, NADA,       "ld_inicio");
    // Load with three LE_MEM wait cycles
    cyc(1, 1, OP_LD, 0, 1, 4'd1, PC|IR|LM,   "ld_busca");
    cyc(1, 1, OP_LD, 0, 1, 4'd2, NADA,       "ld_decod");
    cyc(1, 1, OP_LD, 0, 1, 4'd5, FU,         "ld_calc");
    cyc(1, 1, OP_LD, 0, 0, 4'd6, IOD|LM,     "ld_mem_w1");
    cyc(1, 1, OP_LD, 0, 0, 4'd6, IOD|LM,     "ld_mem_w2");
    cyc(1, 1, OP_LD, 0, 0, 4'd6, IOD|LM,     "ld_mem_w3");
    cyc(1, 1, OP_LD, 0, 1, 4'd6, IOD|LM,     "ld_mem_ok");
    cyc(1, 1, OP_LD, 0, 1, 4'd7, ER|MR,      "ld_escrita");
    cyc(1, 1, OP_ST, 0, 1, 4'd0, NADA,       "st_inicio");
    // Store with one wait
    cyc(1, 1, OP_ST, 0, 1, 4'd1, PC|IR|LM,   "st_busca");
    cyc(1, 1, OP_ST, 0, 1, 4'd2, NADA,       "st_decod");
    cyc(1, 1, OP_ST, 0, 1, 4'd5, FU,         "st_calc");
    cyc(1, 1, OP_ST, 0, 0, 4'd8, EM|IOD|FU,  "st_mem_wait");
    cyc(1, 1, OP_ST, 0, 1, 4'd8, EM|IOD|FU,  "st_mem_ok");
    cyc(1, 1, OP_BR, 0, 1, 4'd0, NADA,       "br1_inicio");
    // Branch taken then not taken
    cyc(1, 1, OP_BR, 0, 1, 4'd1, PC|IR|LM,   "br1_busca");
    cyc(1, 1, OP_BR, 0, 1, 4'd2, NADA,       "br1_decod");
    cyc(1, 1, OP_BR, 1, 1, 4'd9, PC|DS|OPB,  "br1_desvio_z1");
    cyc(1, 1, OP_BR, 0, 1, 4'd0, NADA,       "br2_inicio");
    cyc(1, 1, OP_BR, 0, 1, 4'd1, PC|IR|LM,   "br2_busca");
    cyc(1, 1, OP_BR, 0, 1, 4'd2, NADA,       "br2_decod");
    cyc(1, 1, OP_BR, 0, 1, 4'd9, DS|OPB,     "br2_desvio_z0");
    cyc(1, 1, OP_LD, 0, 1, 4'd0, NADA,       "rst_inicio");
    // Reset while waiting in LE_MEM aborts in the same cycle
    cyc(1, 1, OP_LD, 0, 1, 4'd1, PC|IR|LM,   "rst_busca");
    cyc(1, 1, OP_LD, 0, 1, 4'd2, NADA,       "rst_decod");
    cyc(1, 1, OP_LD, 0, 1, 4'd5, FU,         "rst_calc");
    cyc(1, 1, OP_LD, 0, 0, 4'd6, IOD|LM,     "rst_lemem");
    cyc(0, 1, OP_LD, 0, 0, 4'd0, NADA,       "rst_aborta");
    cyc(1, 1, OP_LD, 0, 0, 4'd0, NADA,       "rst_solto");
    cyc(1, 1, OP_XX, 0, 1, 4'd1, PC|IR|LM,   "il_busca");
    // Illegal opcode sticks despite Habilita and MemPronta
    cyc(1, 1, OP_XX, 0, 1, 4'd2, NADA,       "il_decod");
    for (int i = 0; i < 20; i++)
      cyc(1, 1, OP_XX, 0, 1, 4'd10, IL,      "il_preso");
    cyc(0, 1, OP_XX, 0, 1, 4'd0, NADA,       "il_reset");
    cyc(1, 0, OP_XX, 0, 1, 4'd0, NADA,       "il_liberado");

`ifdef CONTADOR_INSTRUCOES_EN
    for (int i = 0; i < 17; i++) begin
      cyc(1, 1, OP_ST, 0, 1, 4'd0, NADA,       "cnt_inicio");
      cyc(1, 1, OP_ST, 0, 1, 4'd1, PC|IR|LM,   "cnt_busca");
      cyc(1, 1, OP_ST, 0, 1, 4'd2, NADA,       "cnt_decod");
      cyc(1, 1, OP_ST, 0, 1, 4'd5, FU,         "cnt_calc");
      cyc(1, 1, OP_ST, 0, 1, 4'd8, EM|IOD|FU,  "cnt_escmem");
    end
    cyc(1, 0, OP_ST, 0, 1, 4'd0, NADA,         "cnt_fim");
    check_cnt(4'd1, "cnt_wrap");
    cyc(1, 1, OP_XX, 0, 1, 4'd0, NADA,         "cnt_il_inicio");
    cyc(1, 1, OP_XX, 0, 1, 4'd1, PC|IR|LM,     "cnt_il_busca");
    cyc(1, 1, OP_XX, 0, 1, 4'd2, NADA,         "cnt_il_decod");
    cyc(1, 1, OP_XX, 0, 1, 4'd10, IL,          "cnt_il_1");
    cyc(1, 1, OP_XX, 0, 1, 4'd10, IL,          "cnt_il_2");
    check_cnt(4'd1, "cnt_ilegal");
`endif

    repeat (3) @(posedge clk);
    total++;
    if (fila.size() == 0) passou++;
    else $display("FAIL fila_pendente: got %0d entries expected 0", fila.size());
    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
